// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl_if
// Purpose : Display-data load handshake and scanned segment outputs for
//           seg_scan_ctrl. SEG_BRIGHT_EN adds the 4-bit bright input.
// Revision: 1.0
// ============================================================================
interface seg_scan_ctrl_if #(
   parameter int DIGITS = 8
);
   logic [5*DIGITS-1:0] char_in;
   logic [DIGITS-1:0]   dp_in;
   logic                load;
   logic                load_ack;
   logic                frame_done;
   logic [DIGITS-1:0]   an;
   logic [6:0]          seg;
   logic                dp;
`ifdef SEG_BRIGHT_EN
   logic [3:0]          bright;

   modport master (output char_in, dp_in, load, bright,
                   input  load_ack, frame_done, an, seg, dp);
   modport slave  (input  char_in, dp_in, load, bright,
                   output load_ack, frame_done, an, seg, dp);
`else
   modport master (output char_in, dp_in, load,
                   input  load_ack, frame_done, an, seg, dp);
   modport slave  (input  char_in, dp_in, load,
                   output load_ack, frame_done, an, seg, dp);
`endif
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Purpose : Multiplexed 7-segment scan scheduler with per-slot blanking and a
//           double-buffered, frame-synchronous load/ack. Optional macro
//           SEG_BRIGHT_EN adds PWM brightness via bus.bright.
// Revision: 1.0
// ============================================================================
module seg_scan_ctrl #(
   parameter int SCAN_DIV  = 10000,
   parameter int BLANK_CYC = 500,
   parameter int DIGITS    = 8
) (
   input wire             clk,
   input wire             rst_n,
   seg_scan_ctrl_if.slave bus
);
   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

   typedef enum logic [0:0] {BLANK = 1'b0, SHOW = 1'b1} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic                pend;
   logic [5*DIGITS-1:0] act_chr;
   logic [5*DIGITS-1:0] pend_chr;
   logic [DIGITS-1:0]   act_dp;
   logic [DIGITS-1:0]   pend_dp;
   logic [4:0]          cur_code;
   logic                boundary;
   logic                lit;

   assign boundary = (cnt == LAST_CNT) && (idx == LAST_IDX);
   assign cur_code = act_chr[5*idx +: 5];

`ifdef SEG_BRIGHT_EN
   logic [3:0] phase;
   assign lit = (phase <= bus.bright);
`else
   assign lit = 1'b1;
`endif

   // Active-low segment patterns, seg[0]=a .. seg[6]=g
   function automatic logic [6:0] decode(input logic [4:0] code);
      case (code)
         5'd0:    decode = 7'b1000000;
         5'd1:    decode = 7'b1111001;
         5'd2:    decode = 7'b0100100;
         5'd3:    decode = 7'b0110000;
         5'd4:    decode = 7'b0011001;
         5'd5:    decode = 7'b0010010;
         5'd6:    decode = 7'b0000010;
         5'd7:    decode = 7'b1111000;
         5'd8:    decode = 7'b0000000;
         5'd9:    decode = 7'b0010000;
         5'd10:   decode = 7'b0001000;
         5'd11:   decode = 7'b0000011;
         5'd12:   decode = 7'b1000110;
         5'd13:   decode = 7'b0100001;
         5'd14:   decode = 7'b0000110;
         5'd15:   decode = 7'b0001110;
         5'd16:   decode = 7'b0101011;
         5'd17:   decode = 7'b0111111;
         5'd18:   decode = 7'b0101111;
         5'd19:   decode = 7'b0001001;
         5'd20:   decode = 7'b1000111;
         5'd21:   decode = 7'b0001100;
         5'd22:   decode = 7'b1000001;
         default: decode = 7'b1111111;
      endcase
   endfunction

   // Outputs for the slot cycle held in cnt are registered on the same edge
   // that advances cnt, so each edge presents the cycle it just processed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= BLANK;
         cnt            <= '0;
         idx            <= '0;
         pend           <= 1'b0;
         act_chr        <= {DIGITS{5'd31}};
         pend_chr       <= {DIGITS{5'd31}};
         act_dp         <= '0;
         pend_dp        <= '0;
         bus.an         <= '1;
         bus.seg        <= 7'h7F;
         bus.dp         <= 1'b1;
         bus.load_ack   <= 1'b0;
         bus.frame_done <= 1'b0;
`ifdef SEG_BRIGHT_EN
         phase          <= '0;
`endif
      end else begin
         bus.frame_done <= boundary;
         bus.load_ack   <= boundary && (pend || bus.load);

         if (state == SHOW && lit) begin
            bus.an  <= ~(DIGITS'(1) << idx);
            bus.seg <= decode(cur_code);
            bus.dp  <= ~act_dp[idx];
         end else begin
            bus.an  <= '1;
            bus.seg <= 7'h7F;
            bus.dp  <= 1'b1;
         end

         if (cnt == LAST_CNT) begin
            cnt   <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            state <= BLANK;
         end else begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_END)
               state <= SHOW;
         end

`ifdef SEG_BRIGHT_EN
         if (cnt == BLANK_END)
            phase <= '0;
         else if (state == SHOW)
            phase <= phase + 1'b1;
`endif

         // A load coinciding with the boundary bypasses the pending buffer
         if (boundary) begin
            pend <= 1'b0;
            if (bus.load) begin
               act_chr <= bus.char_in;
               act_dp  <= bus.dp_in;
            end else if (pend) begin
               act_chr <= pend_chr;
               act_dp  <= pend_dp;
            end
         end else if (bus.load) begin
            pend_chr <= bus.char_in;
            pend_dp  <= bus.dp_in;
            pend     <= 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Purpose : Scoreboard bench for seg_scan_ctrl (SCAN_DIV=20, BLANK_CYC=4).
// Revision: 1.0
// ============================================================================
module tb_seg_scan_ctrl;
   localparam int SD = 20;
   localparam int BC = 4;
   localparam int D  = 8;
   localparam logic [3:0] BRIGHT = 4'd3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seg_scan_ctrl_if #(.DIGITS(D)) bus ();

   seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .DIGITS(D)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      int            t;
      logic [D-1:0]  an;
      logic [6:0]    seg;
      logic          dp;
      logic          ack;
      logic          fd;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   int           t;
   logic [4:0]   m_act  [D];
   logic [4:0]   m_pbuf [D];
   logic [D-1:0] m_act_dp;
   logic [D-1:0] m_pdp;
   logic         m_pend;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Lit segments in gfedcba order; the display drives the complement
   function automatic logic [6:0] lit_of(input logic [4:0] c);
      case (c)
         5'd0: return 7'b0111111;   5'd1: return 7'b0000110;
         5'd2: return 7'b1011011;   5'd3: return 7'b1001111;
         5'd4: return 7'b1100110;   5'd5: return 7'b1101101;
         5'd6: return 7'b1111101;   5'd7: return 7'b0000111;
         5'd8: return 7'b1111111;   5'd9: return 7'b1101111;
         5'd10: return 7'b1110111;  5'd11: return 7'b1111100;
         5'd12: return 7'b0111001;  5'd13: return 7'b1011110;
         5'd14: return 7'b1111001;  5'd15: return 7'b1110001;
         5'd16: return 7'b1010100;  5'd17: return 7'b1000000;
         5'd18: return 7'b1010000;  5'd19: return 7'b1110110;
         5'd20: return 7'b0111000;  5'd21: return 7'b1110011;
         5'd22: return 7'b0111110;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic model_reset();
      t = 0;
      m_pend = 1'b0;
      m_act_dp = '0;
      m_pdp = '0;
      for (int i = 0; i < D; i++) begin
         m_act[i]  = 5'd31;
         m_pbuf[i] = 5'd31;
      end
   endtask

   task automatic model_step();
      exp_t e;
      int   slot, d;
      logic on, bnd;
      slot = t % SD;
      d    = (t / SD) % D;
      bnd  = (slot == SD - 1) && (d == D - 1);
      on   = (slot >= BC);
`ifdef SEG_BRIGHT_EN
      if (on && (((slot - BC) % 16) > int'(BRIGHT))) on = 1'b0;
`endif
      e.t   = t;
      e.an  = on ? ~(D'(1) << d) : '1;
      e.seg = on ? ~lit_of(m_act[d]) : 7'h7F;
      e.dp  = on ? ~m_act_dp[d] : 1'b1;
      e.fd  = bnd;
      e.ack = bnd && (m_pend || bus.load);
      sb.push_back(e);
      if (bnd) begin
         if (bus.load) begin
            for (int i = 0; i < D; i++) m_act[i] = bus.char_in[5*i +: 5];
            m_act_dp = bus.dp_in;
         end else if (m_pend) begin
            for (int i = 0; i < D; i++) m_act[i] = m_pbuf[i];
            m_act_dp = m_pdp;
         end
         m_pend = 1'b0;
      end else if (bus.load) begin
         for (int i = 0; i < D; i++) m_pbuf[i] = bus.char_in[5*i +: 5];
         m_pdp  = bus.dp_in;
         m_pend = 1'b1;
      end
      t++;
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      model_step();
      @(negedge clk);
      bus.load = 1'b0;
      if (sb.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_val($sformatf("an@%0d", e.t),  32'(bus.an),         32'(e.an));
         check_val($sformatf("seg@%0d", e.t), 32'(bus.seg),        32'(e.seg));
         check_val($sformatf("dp@%0d", e.t),  32'(bus.dp),         32'(e.dp));
         check_val($sformatf("ack@%0d", e.t), 32'(bus.load_ack),   32'(e.ack));
         check_val($sformatf("fd@%0d", e.t),  32'(bus.frame_done), 32'(e.fd));
      end
   endtask

   task automatic run_to(input int n);
      while (t < n) tick();
   endtask

   task automatic do_load(input logic [5*D-1:0] chars, input logic [D-1:0] dps);
      bus.char_in = chars;
      bus.dp_in   = dps;
      bus.load    = 1'b1;
      tick();
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_an"},  32'(bus.an),         32'hFF);
      check_val({tag, "_seg"}, 32'(bus.seg),        32'h7F);
      check_val({tag, "_dp"},  32'(bus.dp),         32'd1);
      check_val({tag, "_ack"}, 32'(bus.load_ack),   32'd0);
      check_val({tag, "_fd"},  32'(bus.frame_done), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.load    = 1'b0;
      bus.char_in = '0;
      bus.dp_in   = '0;
`ifdef SEG_BRIGHT_EN
      bus.bright  = BRIGHT;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outs("rst");
      rst_n = 1'b1;

      // Mid-frame load: frame 0 stays blank, swap at 159
      run_to(50);
      do_load({5'd31, 5'd16, 5'd1, 5'd8, 5'd0, 5'd1, 5'd1, 5'd6}, 8'h00);
      run_to(190);

      // Last load wins, single ack at 319
      do_load({D{5'd1}}, 8'hFF);
      run_to(200);
      do_load({D{5'd8}}, 8'hA5);
      run_to(479);

      // Load on the boundary cycle itself
      do_load({D{5'd0}}, 8'h0F);
      run_to(485);

      // Leave data pending, then reset mid-SHOW of digit 0
      do_load({D{5'd19}}, 8'hFF);
      run_to(490);
      #2 rst_n = 1'b0;
      #1 check_reset_outs("async_rst");
      @(negedge clk);
      check_reset_outs("rst_hold");
      rst_n = 1'b1;
      model_reset();
      run_to(2 * SD * D + 5);

      if (sb.size() != 0) check_val("sb_left", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
